// File: rtl/debounced_edge_detect.sv
// debounced_edge_detect
//
// Purpose:
//   Multi-channel input conditioner. Each channel passes an asynchronous
//   input through a synchroniser. A debounce filter then accepts a new level
//   only after the synchronised input has differed from the current level
//   for DEBOUNCE_CYCLES consecutive cycles. Each accepted transition produces
//   a one-cycle rise or fall pulse. Enabled edges set a sticky per-channel
//   pending flag, which software clears through the clear input.
//
// Parameters:
//   N_CH            number of independent channels (1..32)
//   SYNC_STAGES     synchroniser depth per channel (2..4)
//   DEBOUNCE_CYCLES stable cycles required before a new level is accepted
//                   (1..65535, 1 = no filtering)
//
// Ports:
//   clk          single clock, all state updates on its rising edge
//   rst          synchronous active-high reset
//   async_sig    asynchronous inputs, one bit per channel
//   rise_en      per-channel enable for capturing rising edges into pending
//   fall_en      per-channel enable for capturing falling edges into pending
//   clear        per-channel synchronous clear of pending
//   level        debounced level per channel
//   rise         one-cycle pulse on each accepted 0->1 transition
//   fall         one-cycle pulse on each accepted 1->0 transition
//   pending      sticky per-channel event flag
//   any_pending  registered OR of all pending bits
module debounced_edge_detect #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] async_sig,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  input  logic [N_CH-1:0] clear,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] pending,
  output logic            any_pending
);

  // The counter only has to reach DEBOUNCE_CYCLES-1. It stays at least one
  // bit wide, so the no-filter case (DEBOUNCE_CYCLES = 1) still elaborates.
  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync_out;
  logic [CW-1:0]   cnt_q  [N_CH];
  logic [CW-1:0]   cnt_d  [N_CH];
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] set_evt;
  logic [N_CH-1:0] pending_d;

  // Synchroniser chain. Stage 0 samples the raw asynchronous input, and
  // every later stage copies the stage before it. Reset flushes the chain,
  // so an input that is held high through reset is seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= async_sig;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce filter. The counter records how many consecutive cycles the
  // synchronised input has disagreed with the accepted level. Any cycle of
  // agreement restarts the count. On the last disagreeing cycle the level
  // flips and the counter returns to zero on the same edge. A glitch that
  // is shorter than the window therefore never reaches the level.
  always_comb begin
    level_d = level;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != level[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Pending update. The edge pulses qualified by their enables set the flag.
  // Setting takes priority over clear, so an event that arrives in the same
  // cycle as a clear is not lost.
  always_comb begin
    set_evt   = (rise & rise_en) | (fall & fall_en);
    pending_d = (pending & ~clear) | set_evt;
  end

  // Output registers. rise and fall come from the next-state level, so each
  // pulse lands on the same edge as the level change it reports.
  // any_pending is taken from the next-state pending value, so it moves
  // together with pending and never trails it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= '0;
      rise        <= '0;
      fall        <= '0;
      pending     <= '0;
      any_pending <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level       <= level_d;
      rise        <= level_d & ~level;
      fall        <= ~level_d & level;
      pending     <= pending_d;
      any_pending <= |pending_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/debounced_edge_detect.md
DEBOUNCED_EDGE_DETECT -- requirements
Module: debounced_edge_detect

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent input channels (legal range 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop depth per channel (legal range 2..4).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1, meaning the consecutive cycles of stable new level required before acceptance (legal range 1..65535; 1 = no filtering).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port async_sig, input, N_CH bits: asynchronous inputs, one per channel.
REQ-007 The block SHALL have port rise_en, input, N_CH bits: per-channel enable for rising-edge capture into pending.
REQ-008 The block SHALL have port fall_en, input, N_CH bits: per-channel enable for falling-edge capture into pending.
REQ-009 The block SHALL have port clear, input, N_CH bits: per-channel synchronous clear of pending.
REQ-010 The block SHALL have port level, output, N_CH bits: debounced level per channel.
REQ-011 The block SHALL have port rise, output, N_CH bits: one-cycle pulse on each accepted 0->1 transition.
REQ-012 The block SHALL have port fall, output, N_CH bits: one-cycle pulse on each accepted 1->0 transition.
REQ-013 The block SHALL have port pending, output, N_CH bits: sticky per-channel event flag.
REQ-014 The block SHALL have port any_pending, output, 1 bit: registered OR of all pending bits.

Function
REQ-015 Each channel SHALL shift async_sig[i] through SYNC_STAGES flops; sync_out[i] is the last stage.
REQ-016 Each channel SHALL keep a counter of width max(1, clog2(DEBOUNCE_CYCLES)) bits.
REQ-017 When sync_out == level, the counter SHALL load 0.
REQ-018 When sync_out != level and cnt < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-019 When sync_out != level and cnt == DEBOUNCE_CYCLES-1, level SHALL toggle and cnt SHALL load 0, all on the same edge.
REQ-020 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave level unchanged, with no rise/fall pulse.
REQ-021 rise[i] SHALL be high for exactly the first cycle in which level[i] is 1 after being 0, and SHALL be registered on the same edge as the level change.
REQ-022 fall[i] SHALL be high for exactly the first cycle in which level[i] is 0 after being 1, and SHALL be registered on the same edge as the level change.
REQ-023 rise[i] and fall[i] SHALL never be high together.
REQ-024 Latency: an async_sig change captured by stage 1 at edge k SHALL appear on level/rise/fall after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (edge k+2 for the defaults).
REQ-025 pending[i] SHALL be set on the edge after (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]) is true.
REQ-026 pending[i] SHALL be cleared on the edge after clear[i] is sampled high.
REQ-027 If set and clear are active in the same cycle, set SHALL win so no event is lost.
REQ-028 any_pending SHALL be registered from the next-state value of pending, so it changes on the same edge as pending.
REQ-029 Enable changes SHALL take effect on the next cycle and SHALL NOT affect level, rise or fall.
REQ-030 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be captured.

Reset
REQ-031 While rst is high, all sync flops, counters, level, rise, fall, pending and any_pending SHALL load 0 at the next edge.
REQ-032 rst SHALL override clear and edge set.
REQ-033 Reset asserted mid-debounce SHALL discard the partial count.
REQ-034 An input held high through reset SHALL produce one rise after release, at the normal latency.

Verification
REQ-035 Defaults: async_sig[0] 0->1 before edge k, rise_en=1 -> rise[0]=1 only after edge k+2, level[0]=1, pending[0]=1 after edge k+3, any_pending=1.
REQ-036 DEBOUNCE_CYCLES=4: a 3-cycle high glitch at sync_out -> no level change, no pulse; a 4-cycle stable high -> exactly one rise.
REQ-037 clear[1] and fall[1]&fall_en[1] in the same cycle -> pending[1] remains 1; clear alone next cycle -> pending[1]=0, any_pending=0.
REQ-038 rise_en=0, fall_en=1, input 0->1->0 -> rise and fall both pulse; pending is set only by the fall.
REQ-039 rst pulsed with all inputs high and a debounce in progress -> all outputs 0 the cycle after rst; then one rise per channel at the full latency.
REQ-040 N_CH=8, all channels toggled together -> eight simultaneous rise pulses, and all pending bits set.
